// File: rtl/alu_pipe_pkg.sv
// alu_pipe shared definitions: opcode map, FSM states,
// and the sign-bit overflow rule for add/sub.
package alu_pipe_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_INC = 4'd4;
  localparam logic [3:0] OP_DEC = 4'd5;
  localparam logic [3:0] OP_AND = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;
  localparam logic [3:0] OP_OR  = 4'd8;
  localparam logic [3:0] OP_NOT = 4'd9;

  typedef enum logic {
    IDLE = 1'b0,
    DIV  = 1'b1
  } state_t;

  // sa/sb: operand signs, sr: result sign, sub: 1 for a-b
  function automatic logic add_ov(
    input logic sa,
    input logic sb,
    input logic sr,
    input logic sub
  );
    logic same;
    same = sub ? (sa != sb) : (sa == sb);
    return same && (sr != sa);
  endfunction

endpackage

// File: rtl/alu_pipe_div.sv
// Iterative restoring divide-by-constant, one quotient bit per cycle.
// Ports: clk, rst, start (load dividend), done (quotient valid), quotient.
module alu_pipe_div #(
  parameter int WIDTH = 16,
  parameter int DIV_K = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);
  localparam logic [WIDTH:0] KV = (WIDTH + 1)'(DIV_K);

  logic             busy;
  logic             sgn;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic [WIDTH:0]   t;
  logic [WIDTH-1:0] mag;

  // |min negative| = 2^(WIDTH-1) is exact as an unsigned WIDTH-bit value
  assign mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign t = {r, q[WIDTH-1]};
  assign done = busy && (cnt == LAST);
  assign quotient = sgn ? -q : q;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      sgn  <= 1'b0;
      cnt  <= '0;
      q    <= '0;
      r    <= '0;
    end else if (start) begin
      busy <= 1'b1;
      sgn  <= dividend[WIDTH-1];
      cnt  <= '0;
      q    <= mag;
      r    <= '0;
    end else if (busy) begin
      if (done) begin
        busy <= 1'b0;
      end else begin
        cnt <= cnt + CW'(1);
        if (t >= KV) begin
          r <= WIDTH'(t - KV);
          q <= {q[WIDTH-2:0], 1'b1};
        end else begin
          r <= t[WIDTH-1:0];
          q <= {q[WIDTH-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle ops plus iterative divide-by-constant.
// Ports: in_valid/in_ready/a/b/opcode in, out_valid/out_ready/result/ov/zero/neg/err out.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int MUL_K = 5,
  parameter int DIV_K = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             ov,
  output logic             zero,
  output logic             neg,
  output logic             err
);

  localparam logic [WIDTH-1:0] MAXP = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [2*WIDTH-1:0] KM = (2*WIDTH)'(MUL_K);

  state_t           state;
  logic             acc;
  logic             is_div;
  logic             ddone;
  logic [WIDTH-1:0] dq;
  logic [WIDTH-1:0] cres;
  logic             cov;
  logic             cerr;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]   ph;
  logic             wr;
  logic [WIDTH-1:0] wres;

  assign in_ready = !rst && (state == IDLE) && (!out_valid || out_ready);
  assign acc = in_valid && in_ready;
  assign is_div = (opcode == OP_DIV);

  alu_pipe_div #(
    .WIDTH(WIDTH),
    .DIV_K(DIV_K)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .start   (acc && is_div),
    .dividend(a),
    .done    (ddone),
    .quotient(dq)
  );

  always_comb begin
    prod = {{WIDTH{a[WIDTH-1]}}, a} * KM;
    // product fits iff its top WIDTH+1 bits are all sign copies
    ph = prod[2*WIDTH-1:WIDTH-1];
    cres = '0;
    cov = 1'b0;
    cerr = 1'b0;
    unique case (1'b1)
      (opcode == OP_ADD): begin
        cres = a + b;
        cov = add_ov(a[WIDTH-1], b[WIDTH-1], cres[WIDTH-1], 1'b0);
      end
      (opcode == OP_SUB): begin
        cres = a - b;
        cov = add_ov(a[WIDTH-1], b[WIDTH-1], cres[WIDTH-1], 1'b1);
      end
      (opcode == OP_MUL): begin
        cres = prod[WIDTH-1:0];
        cov = !((&ph) || !(|ph));
      end
      (opcode == OP_DIV): ;
      (opcode == OP_INC): begin
        cres = a + WIDTH'(1);
        cov = (a == MAXP);
      end
      (opcode == OP_DEC): begin
        cres = a - WIDTH'(1);
        cov = (a == MINN);
      end
      (opcode == OP_AND): cres = a & b;
      (opcode == OP_XOR): cres = a ^ b;
      (opcode == OP_OR):  cres = a | b;
      (opcode == OP_NOT): cres = ~a;
      default: cerr = 1'b1;
    endcase
  end

  assign wr = (acc && !is_div) || ((state == DIV) && ddone);
  assign wres = (state == DIV) ? dq : cres;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      ov        <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (wr) begin
        out_valid <= 1'b1;
        result    <= wres;
        ov        <= (state == DIV) ? 1'b0 : cov;
        err       <= (state == DIV) ? 1'b0 : cerr;
        zero      <= (wres == '0);
        neg       <= wres[WIDTH-1];
      end
      if (acc && is_div) state <= DIV;
      else if ((state == DIV) && ddone) state <= IDLE;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed cases then random traffic
// with random back-pressure against an integer reference model.
module tb_alu_pipe;

  localparam int W = 16;
  localparam int MK = 5;
  localparam int DK = 10;
  localparam int DIVLAT = W + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   opcode = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         ov, zero, neg, err;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W), .MUL_K(MK), .DIV_K(DK)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .opcode   (opcode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .ov       (ov),
    .zero     (zero),
    .neg      (neg),
    .err      (err)
  );

  typedef struct {
    logic [W-1:0] res;
    logic ov;
    logic zero;
    logic neg;
    logic err;
    int acc;
    int lat;
  } exp_t;

  exp_t sb[$];
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int stall_until = 0;
  bit rnd_en = 0;
  bit head_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [3:0] op,
                                 input logic [W-1:0] x,
                                 input logic [W-1:0] y);
    exp_t e;
    longint sx, sy, r, mx, mn;
    mx = (longint'(1) << (W - 1)) - 1;
    mn = -mx - 1;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r = 0;
    e.err = 0;
    case (op)
      4'd0: r = sx + sy;
      4'd1: r = sx - sy;
      4'd2: r = sx * MK;
      4'd3: r = sx / DK;
      4'd4: r = sx + 1;
      4'd5: r = sx - 1;
      4'd6: r = longint'(x & y);
      4'd7: r = longint'(x ^ y);
      4'd8: r = longint'(x | y);
      4'd9: r = longint'(~x);
      default: e.err = 1;
    endcase
    e.ov = (op <= 4'd5 && op != 4'd3) ? ((r > mx) || (r < mn)) : 1'b0;
    e.res = r[W-1:0];
    e.zero = (e.res == 0);
    e.neg = e.res[W-1];
    e.lat = (op == 4'd3) ? DIVLAT : 0;
    e.acc = 0;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  // back-pressure source
  initial forever begin
    @(negedge clk);
    if (cyc < stall_until) out_ready = 1'b0;
    else if (rnd_en) out_ready = ($urandom_range(0, 3) != 0);
    else out_ready = 1'b1;
  end

  // monitor: compares every visible output against the queue head
  initial forever begin
    @(negedge clk);
    #2;
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious: got result %0h want no output", result);
      end else begin
        if (!head_seen) begin
          chk("latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
          head_seen = 1;
        end
        chk(out_ready ? "xfer" : "hold",
            {result, ov, zero, neg, err},
            {sb[0].res, sb[0].ov, sb[0].zero, sb[0].neg, sb[0].err});
        if (out_ready) begin
          void'(sb.pop_front());
          head_seen = 0;
        end
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [W-1:0] x,
                      input logic [W-1:0] y, input bit push,
                      output int acc);
    exp_t e;
    bit ok;
    ok = 0;
    acc = -1;
    opcode = op;
    a = x;
    b = y;
    in_valid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      #1;
      if (in_ready) begin
        ok = 1;
        acc = cyc + 1;
        if (push) begin
          e = model(op, x, y);
          e.acc = acc;
          sb.push_back(e);
        end
        @(posedge clk);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got no in_ready want accept op=%0d", op);
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      #3;
      if (sb.size() == 0 && !out_valid) ok = 1;
      @(negedge clk);
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 16'h7FFF;
      1: return 16'h8000;
      2: return 16'h0000;
      3: return 16'hFFFF;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int t0, t1;
    bit flag;
    logic [3:0] op;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 0);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_outputs", {result, ov, zero, neg, err}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 64'(in_ready), 1);
    @(negedge clk);

    send(4'd0, 16'h7FFF, 16'h0001, 1, t0);
    send(4'd0, 16'hFFFB, 16'h0005, 1, t0);
    send(4'd2, 16'h1B58, 16'h0000, 1, t0);
    send(4'd2, 16'hE667, 16'h0000, 1, t0);
    drain();

    send(4'd3, 16'hFFE7, 16'h0000, 1, t0);
    flag = 1;
    for (int i = 0; i < DIVLAT; i++) begin
      #1;
      if (in_ready) flag = 0;
      @(negedge clk);
    end
    chk("div_in_ready_low", 64'(flag), 1);
    send(4'd3, 16'h8000, 16'h0000, 1, t0);
    drain();

    stall_until = cyc + 4;
    send(4'd4, 16'h7FFF, 16'h0000, 1, t0);
    send(4'd5, 16'h8000, 16'h0000, 1, t1);
    chk("b2b_accept_gap", 64'(t1 - t0), 4);
    drain();

    send(4'd12, 16'h0001, 16'h0001, 1, t0);
    send(4'd9, 16'h0000, 16'h0000, 1, t0);
    drain();

    send(4'd3, 16'h0064, 16'h0000, 0, t0);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("in_ready_in_rst", 64'(in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("in_ready_post_abort", 64'(in_ready), 1);
    @(negedge clk);
    flag = 0;
    repeat (DIVLAT + 4) begin
      #1;
      if (out_valid) flag = 1;
      @(negedge clk);
    end
    chk("abort_no_output", 64'(flag), 0);
    send(4'd0, 16'h0002, 16'h0003, 1, t0);
    drain();

    rnd_en = 1;
    repeat (400) begin
      op = 4'($urandom_range(0, 15));
      send(op, pick(), pick(), 1, t0);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    rnd_en = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
